polinomio_horner: RTL

Parametrised sequential polynomial evaluator, the successor of the fixed A*X^2+B*X+C datapath. It computes P(X) = sum c_k*X^k for a runtime-selectable degree up to DEGREE, using Horner's method at one multiply-accumulate per clock. The operating mode is unsigned or two's-complement signed, with sticky overflow detection. It sits under the top-level project and uses the same inicio/pronto handshake.

---
 rtl/polinomio_horner_if.sv | 27 ++
 rtl/polinomio_horner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/polinomio_horner_if.sv
// Handshake and operand bundle for the Horner polynomial evaluator.
`timescale 1ns/1ps
interface polinomio_horner_if #(
    parameter int WIDTH  = 16,
    parameter int DEGREE = 2
);
    localparam int GW = $clog2(DEGREE + 1);

    logic                        inicio;
    logic [GW-1:0]               grau;
    logic [WIDTH-1:0]            X;
    logic [(DEGREE+1)*WIDTH-1:0] coef;
    logic [WIDTH-1:0]            Resultado;
    logic                        pronto;
    logic                        overflow;
    logic                        ocupado;

    modport master (
        output inicio, grau, X, coef,
        input  Resultado, pronto, overflow, ocupado
    );

    modport slave (
        input  inicio, grau, X, coef,
        output Resultado, pronto, overflow, ocupado
    );
endinterface

// File: rtl/polinomio_horner.sv
// Sequential polynomial evaluator: P(X) = sum c_k*X^k via Horner's method,
// one multiply-accumulate per clock, unsigned or two's-complement, with
// sticky per-evaluation overflow.
`timescale 1ns/1ps
module polinomio_horner #(
    parameter int WIDTH  = 16,
    parameter int DEGREE = 2,
    parameter int SIGNED = 0
) (
    input  logic              ck,
    input  logic              rst,
    polinomio_horner_if.slave bus
);
    localparam int GW = $clog2(DEGREE + 1);

    typedef enum logic {OCIOSO, CALC} estado_t;

    estado_t                     state, state_n;
    logic [WIDTH-1:0]            acc, acc_n;
    logic [WIDTH-1:0]            x_r, x_n;
    logic [WIDTH-1:0]            res, res_n;
    logic [(DEGREE+1)*WIDTH-1:0] coef_r, coef_n;
    logic [GW-1:0]               k, k_n, km1, n_clamp;
    logic                        ovf_int, ovf_int_n;
    logic                        ovf_r, ovf_r_n;
    logic                        pronto_r, pronto_n;

    logic [WIDTH-1:0]            cin_a  [DEGREE+1];
    logic [WIDTH-1:0]            creg_a [DEGREE+1];
    logic [2*WIDTH-1:0]          ext_acc, ext_x, prod;
    logic [WIDTH:0]              sum;
    logic [WIDTH-1:0]            c_step, step_acc;
    logic                        mul_ovf, add_ovf, step_ovf;

    // Split the packed coefficient vectors (live input and latched copy) into arrays.
    always_comb begin
        for (int unsigned i = 0; i <= DEGREE; i++) begin
            cin_a[i]  = bus.coef[i*WIDTH +: WIDTH];
            creg_a[i] = coef_r[i*WIDTH +: WIDTH];
        end
    end

    // Requested degree clamped to the largest supported one.
    always_comb begin
        n_clamp = (bus.grau > GW'(DEGREE)) ? GW'(DEGREE) : bus.grau;
    end

    // One Horner step: acc*X + c_(k-1) at full width, plus its overflow flag.
    // A single multiplier serves both modes: the low 2*WIDTH bits of the
    // product of sign-extended operands equal the signed product.
    always_comb begin
        km1    = k - GW'(1);
        c_step = creg_a[km1];
        if (SIGNED != 0) begin
            ext_acc = {{WIDTH{acc[WIDTH-1]}}, acc};
            ext_x   = {{WIDTH{x_r[WIDTH-1]}}, x_r};
        end else begin
            ext_acc = {{WIDTH{1'b0}}, acc};
            ext_x   = {{WIDTH{1'b0}}, x_r};
        end
        prod     = ext_acc * ext_x;
        sum      = {1'b0, prod[WIDTH-1:0]} + {1'b0, c_step};
        step_acc = sum[WIDTH-1:0];
        if (SIGNED != 0) begin
            mul_ovf = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
            add_ovf = (prod[WIDTH-1] == c_step[WIDTH-1]) && (sum[WIDTH-1] != prod[WIDTH-1]);
        end else begin
            mul_ovf = |prod[2*WIDTH-1:WIDTH];
            add_ovf = sum[WIDTH];
        end
        step_ovf = mul_ovf | add_ovf;
    end

    // Next-state and datapath control for the OCIOSO/CALC machine.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        x_n       = x_r;
        coef_n    = coef_r;
        k_n       = k;
        ovf_int_n = ovf_int;
        res_n     = res;
        ovf_r_n   = ovf_r;
        pronto_n  = 1'b0;
        case (state)
            OCIOSO: begin
                if (bus.inicio) begin
                    x_n       = bus.X;
                    coef_n    = bus.coef;
                    k_n       = n_clamp;
                    acc_n     = cin_a[n_clamp];
                    ovf_int_n = 1'b0;
                    state_n   = CALC;
                end
            end
            CALC: begin
                if (k != '0) begin
                    acc_n     = step_acc;
                    k_n       = km1;
                    ovf_int_n = ovf_int | step_ovf;
                end else begin
                    res_n    = acc;
                    ovf_r_n  = ovf_int;
                    pronto_n = 1'b1;
                    state_n  = OCIOSO;
                end
            end
            default: state_n = OCIOSO;
        endcase
    end

    // State and datapath registers; reset abandons any evaluation in flight.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state    <= OCIOSO;
            acc      <= '0;
            x_r      <= '0;
            coef_r   <= '0;
            k        <= '0;
            ovf_int  <= 1'b0;
            res      <= '0;
            ovf_r    <= 1'b0;
            pronto_r <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            x_r      <= x_n;
            coef_r   <= coef_n;
            k        <= k_n;
            ovf_int  <= ovf_int_n;
            res      <= res_n;
            ovf_r    <= ovf_r_n;
            pronto_r <= pronto_n;
        end
    end

    assign bus.Resultado = res;
    assign bus.overflow  = ovf_r;
    assign bus.pronto    = pronto_r;
    assign bus.ocupado   = (state == CALC);
endmodule
